// File: rtl/cache_pkg.sv
// Shared widths, FSM state encodings, request/response bundles and address helpers for the
// cache controller.
package cache_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = TAG_W + IDX_W + WORD_W;

  typedef enum logic [2:0] {
    StInit, StIdle, StCmp, StWbRd, StWbMem, StRfMem, StRfWr, StDone
  } ctrl_state_e;

  typedef enum logic [1:0] {HsIdle, HsReq, HsDrain} hs_state_e;

  // Fields presented to the cache for one access
  typedef struct packed {
    logic              rst;
    logic              comp;
    logic              write;
    logic              valid_in;
    logic [IDX_W-1:0]  index;
    logic [WORD_W-1:0] word;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } cache_req_t;

  // Results captured on the acknowledging edge
  typedef struct packed {
    logic              hit;
    logic              dirty;
    logic              valid;
    logic [TAG_W-1:0]  tag_out;
    logic [DATA_W-1:0] rdata;
  } cache_rsp_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[WORD_W +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[WORD_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0]  tag,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [WORD_W-1:0] word);
    return {tag, idx, word};
  endfunction

endpackage

// File: rtl/cache_hs.sv
// Enable/ack handshake to the cache array. Fields are latched with c_enable on start, held
// until c_ack, results captured on that edge, then the port is quiet until c_ack falls.
module cache_hs
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  cache_req_t        req_i,
  output logic              ready_o,
  output logic              done_o,
  output cache_rsp_t        rsp_o,
  output logic              c_enable_o,
  output logic              c_rst_o,
  output logic              c_comp_o,
  output logic              c_write_o,
  output logic              c_valid_in_o,
  output logic [IDX_W-1:0]  c_index_o,
  output logic [WORD_W-1:0] c_word_o,
  output logic [TAG_W-1:0]  c_tag_o,
  output logic [DATA_W-1:0] c_wdata_o,
  input  logic              c_hit_i,
  input  logic              c_dirty_i,
  input  logic              c_valid_i,
  input  logic              c_ack_i,
  input  logic [TAG_W-1:0]  c_tag_out_i,
  input  logic [DATA_W-1:0] c_rdata_i
);

  hs_state_e  state_q, state_d;
  cache_req_t req_q, req_d;
  cache_rsp_t rsp_q, rsp_d;
  logic       en_q, en_d;
  logic       done_q, done_d;
  cache_rsp_t rsp_in;

  assign rsp_in = {c_hit_i, c_dirty_i, c_valid_i, c_tag_out_i, c_rdata_i};

  // Handshake sequencing: issue, wait for ack, wait for ack release
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    en_d    = en_q;
    done_d  = 1'b0;
    case (state_q)
      HsIdle: if (start_i) begin
        req_d   = req_i;
        en_d    = 1'b1;
        state_d = HsReq;
      end
      HsReq: if (c_ack_i) begin
        rsp_d   = rsp_in;
        en_d    = 1'b0;
        done_d  = 1'b1;
        state_d = HsDrain;
      end
      HsDrain: if (!c_ack_i) state_d = HsIdle;
      default: state_d = HsIdle;
    endcase
  end

  // Handshake state and latched fields/results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HsIdle;
      req_q   <= '0;
      rsp_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign ready_o      = (state_q == HsIdle);
  assign done_o       = done_q;
  assign rsp_o        = rsp_q;
  assign c_enable_o   = en_q;
  assign c_rst_o      = req_q.rst;
  assign c_comp_o     = req_q.comp;
  assign c_write_o    = req_q.write;
  assign c_valid_in_o = req_q.valid_in;
  assign c_index_o    = req_q.index;
  assign c_word_o     = req_q.word;
  assign c_tag_o      = req_q.tag;
  assign c_wdata_o    = req_q.wdata;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: invalidate-all after reset, compare, dirty write-back and
// write-allocate refill over a word-wide memory port.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic              c_enable,
  output logic              c_rst,
  output logic              c_comp,
  output logic              c_write,
  output logic              c_valid_in,
  output logic [IDX_W-1:0]  c_index,
  output logic [WORD_W-1:0] c_word,
  output logic [TAG_W-1:0]  c_tag,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic              c_ack,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;
  logic              pend_q, pend_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic       hs_start, hs_ready, hs_done;
  cache_req_t hs_req;
  cache_rsp_t hs_rsp;

  cache_hs u_hs (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (hs_start),
    .req_i        (hs_req),
    .ready_o      (hs_ready),
    .done_o       (hs_done),
    .rsp_o        (hs_rsp),
    .c_enable_o   (c_enable),
    .c_rst_o      (c_rst),
    .c_comp_o     (c_comp),
    .c_write_o    (c_write),
    .c_valid_in_o (c_valid_in),
    .c_index_o    (c_index),
    .c_word_o     (c_word),
    .c_tag_o      (c_tag),
    .c_wdata_o    (c_wdata),
    .c_hit_i      (c_hit),
    .c_dirty_i    (c_dirty),
    .c_valid_i    (c_valid),
    .c_ack_i      (c_ack),
    .c_tag_out_i  (c_tag_out),
    .c_rdata_i    (c_rdata)
  );

  // Cache access fields for the current state; one access per visit, tracked by pend_q
  always_comb begin
    hs_req       = '0;
    hs_req.index = addr_idx(req_addr_q);
    hs_req.word  = cnt_q;
    hs_req.tag   = addr_tag(req_addr_q);
    hs_req.wdata = req_wdata_q;
    unique case (state_q)
      StInit: begin
        hs_req.rst   = 1'b1;
        hs_req.index = init_idx_q;
        hs_req.word  = '0;
        hs_req.tag   = '0;
      end
      StCmp: begin
        hs_req.comp  = 1'b1;
        hs_req.write = req_wr_q;
        hs_req.word  = addr_word(req_addr_q);
      end
      StRfWr: begin
        hs_req.write    = 1'b1;
        hs_req.valid_in = 1'b1;
        hs_req.wdata    = rf_data_q;
      end
      default: ;
    endcase
  end

  assign hs_start = (state_q inside {StInit, StCmp, StWbRd, StRfWr}) && !pend_q && hs_ready;

  // Next-state, request capture and memory port sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    pend_d      = pend_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rf_data_d   = rf_data_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (hs_start) pend_d = 1'b1;
    unique case (state_q)
      StInit: if (hs_done) begin
        pend_d     = 1'b0;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == '1) state_d = StIdle;
      end
      StIdle: if (cpu_req) begin
        req_wr_d    = cpu_wr;
        req_addr_d  = cpu_addr;
        req_wdata_d = cpu_wdata;
        state_d     = StCmp;
      end
      StCmp: if (hs_done) begin
        pend_d = 1'b0;
        cnt_d  = '0;
        if (hs_rsp.hit) begin
          if (!req_wr_q) rdata_d = hs_rsp.rdata;
          state_d = StDone;
        end else if (hs_rsp.valid && hs_rsp.dirty) begin
          state_d = StWbRd;
        end else begin
          state_d = StRfMem;
        end
      end
      StWbRd: if (hs_done) begin
        pend_d  = 1'b0;
        state_d = StWbMem;
      end
      // Write back the word just read; hs_rsp holds it until the next access
      StWbMem: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = make_addr(hs_rsp.tag_out, addr_idx(req_addr_q), cnt_q);
          mem_wdata_d = hs_rsp.rdata;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          state_d   = (cnt_q == '1) ? StRfMem : StWbRd;
        end
      end
      StRfMem: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = make_addr(addr_tag(req_addr_q), addr_idx(req_addr_q), cnt_q);
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          rf_data_d = mem_rdata;
          state_d   = StRfWr;
        end
      end
      // After the last word the compare is retried and is guaranteed to hit
      StRfWr: if (hs_done) begin
        pend_d  = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == '1) ? StCmp : StRfMem;
      end
      StDone: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_idx_q  <= '0;
      pend_q      <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rf_data_q   <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      pend_q      <= pend_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rf_data_q   <= rf_data_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ready = (state_q == StDone);
  assign cpu_rdata = rdata_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic        first_q, first_d;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Count only the first compare of each request, saturating
  always_comb begin
    first_d    = first_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && cpu_req) first_d = 1'b1;
    if (state_q == StCmp && hs_done) begin
      first_d = 1'b0;
      if (first_q) begin
        if (hs_rsp.hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
